hdmi_data_island_decoder: RTL and testbench

- Receive-side counterpart of the HDMI data-island packet encoder. Consumes the per-pixel 4-bit TERC4-decoded nibbles of channels 0/1/2 plus a data-island-active flag.
- Reassembles 32-cycle packets, checks every BCH parity byte, and presents the header and subpackets.
- Additionally decodes Audio Clock Regeneration packets (N/CTS) and Audio Sample packets (16-bit L/R stream). Sits behind the TMDS/TERC4 decoder in the HDMI capture/loopback path.

---
 rtl/hdmi_data_island_decoder.sv | 189 ++++++++++++++++++
 tb/tb_hdmi_data_island_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_data_island_decoder.sv
// HDMI data-island receiver: rebuilds 32-cycle packets from TERC4 nibbles, checks BCH
// parity, and extracts ACR (N/CTS) and audio-sample payloads.
module hdmi_data_island_decoder #(
    parameter int DROP_BAD_AUDIO = 1,
    parameter int CHECK_FRAMING  = 1
) (
    input  logic        i_pixclk,
    input  logic        i_reset_n,
    input  logic [3:0]  i_d0,
    input  logic [3:0]  i_d1,
    input  logic [3:0]  i_d2,
    input  logic        i_data,
    output logic [23:0] o_hdr,
    output logic [55:0] o_sub0,
    output logic [55:0] o_sub1,
    output logic [55:0] o_sub2,
    output logic [55:0] o_sub3,
    output logic        o_hdr_err,
    output logic [3:0]  o_sub_err,
    output logic        o_pkt_valid,
    output logic        o_frame_err,
    output logic [19:0] o_cts,
    output logic [19:0] o_n,
    output logic        o_acr_valid,
    output logic [15:0] o_audio_l,
    output logic [15:0] o_audio_r,
    output logic        o_audio_valid,
    output logic        o_hsync,
    output logic        o_vsync
);

    logic [4:0]       cnt;
    logic             data_q;
    logic             first;
    logic             gbad;
    logic             hbad;
    logic [7:0]       hcode;
    logic [3:0][7:0]  scode;
    logic [3:0]       sbad;
    logic [23:0]      hdr_sh;
    logic [3:0][55:0] sub_sh;
    logic [3:0][55:0] sub_q;
    logic [3:0]       amask;

    logic             rise;
    logic             cur_first;
    logic             gexp;
    logic             gbad_n;
    logic             hbad_n;
    logic [7:0]       hcode_n;
    logic [3:0][7:0]  scode_n;
    logic [3:0]       sbad_n;
    logic [23:0]      hdr_sh_n;
    logic [3:0][55:0] sub_sh_n;
    logic             pkt_done;
    logic             pkt_ok;
    logic [3:0]       drop_mask;
    logic [1:0]       aidx;

    assign o_sub0 = sub_q[0];
    assign o_sub1 = sub_q[1];
    assign o_sub2 = sub_q[2];
    assign o_sub3 = sub_q[3];

    function automatic logic [7:0] bch_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'hC1 : 8'h00);
    endfunction

    always_comb begin
        rise      = i_data & ~data_q;
        cur_first = rise | first;
        gexp      = ~(cur_first && cnt == 5'd0);
        gbad_n    = ((cnt == 5'd0) ? 1'b0 : gbad) | (i_d0[3] != gexp);

        // Header: 24 data bits feed the LFSR, then 8 parity bits are checked MSB-first.
        hcode_n  = (cnt == 5'd0) ? 8'h00 : hcode;
        hbad_n   = (cnt == 5'd0) ? 1'b0 : hbad;
        hdr_sh_n = hdr_sh;
        if (cnt < 5'd24) begin
            hcode_n  = bch_step(hcode_n, i_d0[2]);
            hdr_sh_n = {i_d0[2], hdr_sh[23:1]};
        end else begin
            hbad_n  = hbad_n | (i_d0[2] != hcode_n[7]);
            hcode_n = {hcode_n[6:0], 1'b0};
        end

        for (int k = 0; k < 4; k++) begin
            scode_n[k]  = (cnt == 5'd0) ? 8'h00 : scode[k];
            sbad_n[k]   = (cnt == 5'd0) ? 1'b0 : sbad[k];
            sub_sh_n[k] = sub_sh[k];
            if (cnt < 5'd28) begin
                scode_n[k]  = bch_step(bch_step(scode_n[k], i_d1[k]), i_d2[k]);
                sub_sh_n[k] = {i_d2[k], i_d1[k], sub_sh[k][55:2]};
            end else begin
                sbad_n[k]  = sbad_n[k] | (i_d1[k] != scode_n[k][7]) | (i_d2[k] != scode_n[k][6]);
                scode_n[k] = {scode_n[k][5:0], 2'b00};
            end
        end

        pkt_done  = i_data && (cnt == 5'd31);
        pkt_ok    = !((CHECK_FRAMING != 0) && gbad_n);
        drop_mask = (DROP_BAD_AUDIO != 0) ? sbad_n : 4'b0000;

        aidx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (amask[k]) aidx = 2'(k);
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt           <= '0;
            data_q        <= 1'b0;
            first         <= 1'b0;
            gbad          <= 1'b0;
            hbad          <= 1'b0;
            hcode         <= '0;
            scode         <= '0;
            sbad          <= '0;
            hdr_sh        <= '0;
            sub_sh        <= '0;
            sub_q         <= '0;
            amask         <= '0;
            o_hdr         <= '0;
            o_hdr_err     <= 1'b0;
            o_sub_err     <= '0;
            o_pkt_valid   <= 1'b0;
            o_frame_err   <= 1'b0;
            o_cts         <= '0;
            o_n           <= '0;
            o_acr_valid   <= 1'b0;
            o_audio_l     <= '0;
            o_audio_r     <= '0;
            o_audio_valid <= 1'b0;
            o_hsync       <= 1'b0;
            o_vsync       <= 1'b0;
        end else begin
            data_q        <= i_data;
            o_pkt_valid   <= 1'b0;
            o_frame_err   <= 1'b0;
            o_acr_valid   <= 1'b0;
            o_audio_valid <= 1'b0;

            if (i_data) begin
                cnt     <= cnt + 5'd1;
                first   <= (cnt == 5'd31) ? 1'b0 : cur_first;
                gbad    <= gbad_n;
                hbad    <= hbad_n;
                hcode   <= hcode_n;
                scode   <= scode_n;
                sbad    <= sbad_n;
                hdr_sh  <= hdr_sh_n;
                sub_sh  <= sub_sh_n;
                o_hsync <= i_d0[0];
                o_vsync <= i_d0[1];
            end else if (data_q && cnt != 5'd0) begin
                // Island ended mid-packet: drop the partial packet.
                o_frame_err <= 1'b1;
                cnt         <= '0;
            end

            if (pkt_done) begin
                if (pkt_ok) begin
                    o_pkt_valid <= 1'b1;
                    o_hdr       <= hdr_sh_n;
                    sub_q       <= sub_sh_n;
                    o_hdr_err   <= hbad_n;
                    o_sub_err   <= sbad_n;
                    if (!hbad_n && hdr_sh_n[7:0] == 8'h01) begin
                        o_cts       <= {sub_sh_n[0][11:8], sub_sh_n[0][23:16], sub_sh_n[0][31:24]};
                        o_n         <= {sub_sh_n[0][35:32], sub_sh_n[0][47:40], sub_sh_n[0][55:48]};
                        o_acr_valid <= 1'b1;
                    end
                    if (!hbad_n && hdr_sh_n[7:0] == 8'h02)
                        amask <= hdr_sh_n[11:8] & ~drop_mask;
                end else begin
                    o_frame_err <= 1'b1;
                end
            end else if (amask != 4'b0000) begin
                // One present sample per cycle, lowest subpacket first.
                o_audio_l     <= sub_q[aidx][23:8];
                o_audio_r     <= sub_q[aidx][47:32];
                o_audio_valid <= 1'b1;
                amask[aidx]   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
// Directed bench for hdmi_data_island_decoder: table of packets plus framing, abort and
// reset sequences; a second instance runs with DROP_BAD_AUDIO=0.
module tb_hdmi_data_island_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  d0 = '0, d1 = '0, d2 = '0;
    logic        data = 1'b0;

    logic [23:0] o_hdr;
    logic [55:0] o_sub0, o_sub1, o_sub2, o_sub3;
    logic        o_hdr_err, o_pkt_valid, o_frame_err, o_acr_valid, o_audio_valid, o_hsync, o_vsync;
    logic [3:0]  o_sub_err;
    logic [19:0] o_cts, o_n;
    logic [15:0] o_audio_l, o_audio_r;

    logic [23:0] b_hdr;
    logic [55:0] b_sub0, b_sub1, b_sub2, b_sub3;
    logic        b_hdr_err, b_pkt_valid, b_frame_err, b_acr_valid, b_audio_valid, b_hsync, b_vsync;
    logic [3:0]  b_sub_err;
    logic [19:0] b_cts, b_n;
    logic [15:0] b_audio_l, b_audio_r;

    always #5 clk = ~clk;

    hdmi_data_island_decoder #(.DROP_BAD_AUDIO(1), .CHECK_FRAMING(1)) dut (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_d0(d0), .i_d1(d1), .i_d2(d2), .i_data(data),
        .o_hdr(o_hdr), .o_sub0(o_sub0), .o_sub1(o_sub1), .o_sub2(o_sub2), .o_sub3(o_sub3),
        .o_hdr_err(o_hdr_err), .o_sub_err(o_sub_err), .o_pkt_valid(o_pkt_valid),
        .o_frame_err(o_frame_err), .o_cts(o_cts), .o_n(o_n), .o_acr_valid(o_acr_valid),
        .o_audio_l(o_audio_l), .o_audio_r(o_audio_r), .o_audio_valid(o_audio_valid),
        .o_hsync(o_hsync), .o_vsync(o_vsync));

    hdmi_data_island_decoder #(.DROP_BAD_AUDIO(0), .CHECK_FRAMING(1)) dut_keep (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_d0(d0), .i_d1(d1), .i_d2(d2), .i_data(data),
        .o_hdr(b_hdr), .o_sub0(b_sub0), .o_sub1(b_sub1), .o_sub2(b_sub2), .o_sub3(b_sub3),
        .o_hdr_err(b_hdr_err), .o_sub_err(b_sub_err), .o_pkt_valid(b_pkt_valid),
        .o_frame_err(b_frame_err), .o_cts(b_cts), .o_n(b_n), .o_acr_valid(b_acr_valid),
        .o_audio_l(b_audio_l), .o_audio_r(b_audio_r), .o_audio_valid(b_audio_valid),
        .o_hsync(b_hsync), .o_vsync(b_vsync));

    int n_chk = 0, n_fail = 0;
    int cyc = 0, pv_cnt = 0, fe_cnt = 0, acr_cnt = 0, aud_cnt = 0, aud2_cnt = 0;
    logic [31:0] aud_q[$];
    int          aud_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_pkt_valid) pv_cnt++;
        if (o_frame_err) fe_cnt++;
        if (o_acr_valid) acr_cnt++;
        if (o_audio_valid) begin
            aud_cnt++;
            aud_q.push_back({o_audio_l, o_audio_r});
            aud_cyc.push_back(cyc);
        end
        if (b_audio_valid) aud2_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // BCH parity byte as transmitted: bit i of the byte is the i-th parity bit sent.
    function automatic logic [7:0] par(input logic [55:0] d, input int n);
        logic [7:0] c;
        logic [7:0] p;
        c = 8'h00;
        for (int i = 0; i < n; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'hC1 : 8'h00);
        for (int i = 0; i < 8; i++) p[i] = c[7-i];
        return p;
    endfunction

    logic [31:0]      h_full;
    logic [3:0][63:0] s_full;

    task automatic build(input logic [23:0] hdr, input logic [3:0][55:0] sub,
                         input logic hflip, input logic [3:0] sflip);
        h_full = {par({32'h0, hdr}, 24), hdr};
        h_full[24] = h_full[24] ^ hflip;
        for (int k = 0; k < 4; k++) begin
            s_full[k] = {par(sub[k], 56), sub[k]};
            s_full[k][60] = s_full[k][60] ^ sflip[k];
        end
    endtask

    task automatic send(input logic first_pkt, input int force_cyc, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            data  = 1'b1;
            d0[3] = (c == force_cyc) ? 1'b0 : !(first_pkt && c == 0);
            d0[2] = h_full[c];
            d0[1] = c[1];
            d0[0] = c[0];
            for (int k = 0; k < 4; k++) begin
                d1[k] = s_full[k][2*c];
                d2[k] = s_full[k][2*c+1];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data = 1'b0;
            d0 = '0; d1 = '0; d2 = '0;
        end
        #1;
    endtask

    typedef struct {
        logic [23:0]      hdr;
        logic [3:0][55:0] sub;
        logic             hflip;
        logic [3:0]       sflip;
        logic             herr;
        logic [3:0]       serr;
        logic             acr;
        logic [19:0]      n;
        logic [19:0]      cts;
        int               naud;
        int               naud2;
        logic [31:0]      a0;
        logic [31:0]      a1;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        int pv0, fe0, acr0, aud0, aud20, snap;

        vecs[0] = '{24'h000001, {4{56'h00180078690000}}, 1'b0, 4'b0000,
                    1'b0, 4'b0000, 1'b1, 20'h01800, 20'h06978, 0, 0, 32'h0, 32'h0};
        vecs[1] = '{24'h000502, {56'h22222222222222, 56'h007FFF00800000, 56'h11111111111111, 56'h00ABCD00123400},
                    1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 20'h01800, 20'h06978, 2, 2, 32'h1234ABCD, 32'h80007FFF};
        vecs[2] = '{24'h000302, {56'h0, 56'h0, 56'h00444400333300, 56'h00222200111100},
                    1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 20'h01800, 20'h06978, 1, 2, 32'h11112222, 32'h0};
        vecs[3] = '{24'h0D0282, {56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h55AA55AA55AA55, 56'h80000000000001},
                    1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 20'h01800, 20'h06978, 0, 0, 32'h0, 32'h0};
        vecs[4] = '{24'h000001, {4{56'h00100045230100}}, 1'b1, 4'b0000,
                    1'b1, 4'b0000, 1'b0, 20'h01800, 20'h06978, 0, 0, 32'h0, 32'h0};
        vecs[5] = '{24'h000F02, {4{56'h00BEEF00CAFE00}}, 1'b1, 4'b1000,
                    1'b1, 4'b1000, 1'b0, 20'h01800, 20'h06978, 0, 0, 32'h0, 32'h0};
        vecs[6] = '{24'h000001, {4{56'h00100045230100}}, 1'b0, 4'b0000,
                    1'b0, 4'b0000, 1'b1, 20'h01000, 20'h12345, 0, 0, 32'h0, 32'h0};

        #12;
        check("rst_hdr", o_hdr, 24'h0);
        check("rst_sub0", o_sub0, 56'h0);
        check("rst_pkt_valid", o_pkt_valid, 1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        check("rst_n_cts", {o_n, o_cts}, 40'h0);
        check("rst_audio", {o_audio_valid, o_audio_l, o_audio_r}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            pv0 = pv_cnt; fe0 = fe_cnt; acr0 = acr_cnt; aud0 = aud_cnt; aud20 = aud2_cnt;
            aud_q.delete(); aud_cyc.delete();
            build(vecs[i].hdr, vecs[i].sub, vecs[i].hflip, vecs[i].sflip);
            send(1'b1, -1, 32);
            @(negedge clk);
            check($sformatf("v%0d_latency", i), o_pkt_valid, 1'b1);
            data = 1'b0;
            idle(8);
            check($sformatf("v%0d_pv_count", i), pv_cnt - pv0, 1);
            check($sformatf("v%0d_fe_count", i), fe_cnt - fe0, 0);
            check($sformatf("v%0d_hdr", i), o_hdr, vecs[i].hdr);
            check($sformatf("v%0d_sub0", i), o_sub0, vecs[i].sub[0]);
            check($sformatf("v%0d_sub1", i), o_sub1, vecs[i].sub[1]);
            check($sformatf("v%0d_sub2", i), o_sub2, vecs[i].sub[2]);
            check($sformatf("v%0d_sub3", i), o_sub3, vecs[i].sub[3]);
            check($sformatf("v%0d_hdr_err", i), o_hdr_err, vecs[i].herr);
            check($sformatf("v%0d_sub_err", i), o_sub_err, vecs[i].serr);
            check($sformatf("v%0d_acr_count", i), acr_cnt - acr0, vecs[i].acr ? 1 : 0);
            check($sformatf("v%0d_n", i), o_n, vecs[i].n);
            check($sformatf("v%0d_cts", i), o_cts, vecs[i].cts);
            check($sformatf("v%0d_audio_count", i), aud_cnt - aud0, vecs[i].naud);
            check($sformatf("v%0d_audio_count_keep", i), aud2_cnt - aud20, vecs[i].naud2);
            if (vecs[i].naud >= 1)
                check($sformatf("v%0d_sample0", i), (aud_q.size() > 0) ? aud_q[0] : 32'h0, vecs[i].a0);
            if (vecs[i].naud >= 2) begin
                check($sformatf("v%0d_sample1", i), (aud_q.size() > 1) ? aud_q[1] : 32'h0, vecs[i].a1);
                check($sformatf("v%0d_consecutive", i),
                      (aud_cyc.size() > 1) ? aud_cyc[1] - aud_cyc[0] : 0, 1);
            end
        end
        check("sync_hold", {o_vsync, o_hsync}, 2'b11);

        // Back-to-back packets with correct continuation guard bits.
        pv0 = pv_cnt; fe0 = fe_cnt;
        build(24'h0A0182, {4{56'h0}}, 1'b0, 4'b0);
        send(1'b1, -1, 32);
        build(24'h0B0183, {4{56'h13579BDF2468AC}}, 1'b0, 4'b0);
        send(1'b0, -1, 32);
        @(negedge clk);
        check("b2b_latency", o_pkt_valid, 1'b1);
        data = 1'b0;
        idle(6);
        check("b2b_pv_count", pv_cnt - pv0, 2);
        check("b2b_fe_count", fe_cnt - fe0, 0);
        check("b2b_hdr", o_hdr, 24'h0B0183);

        // Same pair with the guard bit dropped at overall cycle 40.
        pv0 = pv_cnt; fe0 = fe_cnt;
        build(24'h0A0182, {4{56'h0}}, 1'b0, 4'b0);
        send(1'b1, -1, 32);
        build(24'h0C0184, {4{56'h13579BDF2468AC}}, 1'b0, 4'b0);
        send(1'b0, 8, 32);
        @(negedge clk);
        check("guard_fe_strobe", o_frame_err, 1'b1);
        data = 1'b0;
        idle(6);
        check("guard_pv_count", pv_cnt - pv0, 1);
        check("guard_fe_count", fe_cnt - fe0, 1);
        check("guard_hdr_held", o_hdr, 24'h0A0182);

        // Island ends at cnt=17, then a clean packet follows.
        pv0 = pv_cnt; fe0 = fe_cnt;
        build(24'h0E0185, {4{56'hFFFFFFFFFFFFFF}}, 1'b0, 4'b0);
        send(1'b1, -1, 17);
        idle(6);
        check("abort_fe_count", fe_cnt - fe0, 1);
        check("abort_pv_count", pv_cnt - pv0, 0);
        check("abort_hdr_held", o_hdr, 24'h0A0182);
        check("abort_sub_held", o_sub0, 56'h0);
        pv0 = pv_cnt; fe0 = fe_cnt;
        build(24'h000001, {4{56'h00180078690000}}, 1'b0, 4'b0);
        send(1'b1, -1, 32);
        idle(6);
        check("reacq_pv_count", pv_cnt - pv0, 1);
        check("reacq_fe_count", fe_cnt - fe0, 0);
        check("reacq_hdr", o_hdr, 24'h000001);
        check("reacq_n", o_n, 20'h01800);

        // Reset while the audio emitter is running.
        build(24'h000F02, {56'h00444400333300, 56'h00333300222200, 56'h00222200111100, 56'h00111100000000},
              1'b0, 4'b0);
        send(1'b1, -1, 32);
        @(negedge clk);
        data = 1'b0; d0 = '0; d1 = '0; d2 = '0;
        for (int t = 0; t < 10 && !o_audio_valid; t++) @(negedge clk);
        check("rst_emit_seen", o_audio_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        snap = aud_cnt;
        check("midrst_audio_valid", o_audio_valid, 1'b0);
        check("midrst_audio_lr", {o_audio_l, o_audio_r}, 32'h0);
        check("midrst_hdr", o_hdr, 24'h0);
        check("midrst_sub0", o_sub0, 56'h0);
        check("midrst_n_cts", {o_n, o_cts}, 40'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        check("midrst_no_more_audio", aud_cnt - snap, 0);
        check("midrst_no_pkt", o_pkt_valid | o_frame_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
